// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared I2S control definitions.
//   OP_t          - operating options (mode, stereo, frame_size)
//   sync_state_t  - receive-clock lock states (UNLOCKED, ALIGN, LOCKED)
//   LOCK_CHANS    - good channels needed in ALIGN before LOCKED
//   SCLK_TIMEOUT_CYC - pclk cycles without an sclk edge that count as sclk lost
//   chan_len()    - expected channel length in sclk rises for a frame size
package ctrl_pkg;

   typedef enum logic [1:0] {
      MT = 2'd0,   // master transmit
      MR = 2'd1,   // master receive
      ST = 2'd2,   // slave transmit
      SR = 2'd3    // slave receive
   } op_mode_t;

   typedef enum logic {
      f16bits = 1'b0,
      f32bits = 1'b1
   } frame_size_t;

   typedef struct packed {
      op_mode_t    mode;
      logic        stereo;
      frame_size_t frame_size;
   } OP_t;

   typedef logic [1:0] sync_state_t;
   localparam sync_state_t UNLOCKED = 2'd0;
   localparam sync_state_t ALIGN    = 2'd1;
   localparam sync_state_t LOCKED   = 2'd2;

   localparam int LOCK_CHANS       = 2;
   localparam int SCLK_TIMEOUT_CYC = 64;

   // Channel length does not depend on stereo/mono.
   function automatic logic [5:0] chan_len(input frame_size_t fs);
      return (fs == f32bits) ? 6'd32 : 6'd16;
   endfunction

endpackage

// File: rtl/clk_rx_sync_sync2.sv
// sync2: generic two-flop synchronizer into the pclk domain.
//   pclk  - destination clock
//   rst_  - asynchronous active-low reset, clears both flops
//   d     - asynchronous input
//   q     - synchronized output (second flop)
module sync2 (
   input  logic pclk,
   input  logic rst_,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge pclk or negedge rst_) begin
      if (!rst_) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/clk_rx_sync.sv
// clk_rx_sync: brings an external I2S sclk/ws pair into the pclk domain,
// produces per-edge pulses, counts bits per channel and tracks channel-length
// lock (UNLOCKED -> ALIGN -> LOCKED).
// Optional sclk-loss timeout is compiled in with `define CLK_RX_SYNC_TIMEOUT_EN.
// Ports:
//   pclk, rst_    - system clock, asynchronous active-low reset
//   OP            - operating options; active only in slave modes ST/SR
//   sclk_in/ws_in - external serial clock / word select (async to pclk)
//   sclk_rise/sclk_fall - one-pclk pulse per detected sclk edge
//   ws_sync       - ws sampled at the last sclk rise
//   frame_start   - pulse at each ws 1->0 boundary
//   bit_cnt       - sclk rises in the current channel (saturates at 63)
//   locked        - high while in LOCKED
//   frame_err     - pulse on a channel-length mismatch (ALIGN/LOCKED)
//   sclk_lost     - pulse on sclk timeout (0 when timeout compiled out)
//   state_dbg     - current lock state, for observation
module clk_rx_sync
   import ctrl_pkg::*;
(
   input  logic        pclk,
   input  logic        rst_,
   input  OP_t         OP,
   input  logic        sclk_in,
   input  logic        ws_in,
   output logic        sclk_rise,
   output logic        sclk_fall,
   output logic        ws_sync,
   output logic        frame_start,
   output logic [5:0]  bit_cnt,
   output logic        locked,
   output logic        frame_err,
   output logic        sclk_lost,
   output sync_state_t state_dbg
);

   logic        active;
   logic        sclk_s, ws_s;
   logic        sclk_h, ws_h;
   logic        rise_det, fall_det;
   logic        boundary, len_ok;
   logic        timeout_hit;
   logic [5:0]  exp_len;
   logic [1:0]  good_cnt;
   sync_state_t state;

   // stereo does not change the channel length
   logic unused_op;
   assign unused_op = OP.stereo;

   assign active = (OP.mode == ST) || (OP.mode == SR);

   sync2 u_sync_sclk (.pclk(pclk), .rst_(rst_), .d(sclk_in), .q(sclk_s));
   sync2 u_sync_ws   (.pclk(pclk), .rst_(rst_), .d(ws_in),   .q(ws_s));

   // Edge detect between the history flop and the second sync flop; the
   // registered pulse lands 3 pclk after the sclk_in edge. ws_h is used as
   // the ws sample so ws is taken one stage later than the sclk edge.
   assign rise_det = active & sclk_s & ~sclk_h;
   assign fall_det = active & ~sclk_s & sclk_h;
   assign boundary = rise_det && (ws_h != ws_sync);
   assign exp_len  = chan_len(OP.frame_size);
   assign len_ok   = (bit_cnt == exp_len);

`ifdef CLK_RX_SYNC_TIMEOUT_EN
   logic [6:0] tcnt;
   logic       lost_q;

   // Fires once as the counter steps onto SCLK_TIMEOUT_CYC; the counter then
   // holds there until the next sclk edge, so the pulse cannot repeat.
   assign timeout_hit = active && !(rise_det || fall_det) &&
                        (tcnt == 7'(SCLK_TIMEOUT_CYC - 1));

   always_ff @(posedge pclk or negedge rst_) begin
      if (!rst_) begin
         tcnt   <= 7'd0;
         lost_q <= 1'b0;
      end else if (!active) begin
         tcnt   <= 7'd0;
         lost_q <= 1'b0;
      end else begin
         lost_q <= timeout_hit;
         if (rise_det || fall_det)
            tcnt <= 7'd0;
         else if (tcnt != 7'(SCLK_TIMEOUT_CYC))
            tcnt <= tcnt + 7'd1;
      end
   end

   assign sclk_lost = lost_q;
`else
   assign timeout_hit = 1'b0;
   assign sclk_lost   = 1'b0;
`endif

   always_ff @(posedge pclk or negedge rst_) begin
      if (!rst_) begin
         sclk_h      <= 1'b0;
         ws_h        <= 1'b0;
         sclk_rise   <= 1'b0;
         sclk_fall   <= 1'b0;
         ws_sync     <= 1'b0;
         frame_start <= 1'b0;
         frame_err   <= 1'b0;
         bit_cnt     <= 6'd0;
         good_cnt    <= 2'd0;
         state       <= UNLOCKED;
      end else if (!active) begin
         sclk_h      <= 1'b0;
         ws_h        <= 1'b0;
         sclk_rise   <= 1'b0;
         sclk_fall   <= 1'b0;
         ws_sync     <= 1'b0;
         frame_start <= 1'b0;
         frame_err   <= 1'b0;
         bit_cnt     <= 6'd0;
         good_cnt    <= 2'd0;
         state       <= UNLOCKED;
      end else begin
         sclk_h      <= sclk_s;
         ws_h        <= ws_s;
         sclk_rise   <= rise_det;
         sclk_fall   <= fall_det;
         frame_start <= 1'b0;
         frame_err   <= 1'b0;
         if (timeout_hit) begin
            // Timeout wins over any boundary in the same cycle.
            state    <= UNLOCKED;
            bit_cnt  <= 6'd0;
            good_cnt <= 2'd0;
         end else if (rise_det) begin
            ws_sync <= ws_h;
            if (boundary) begin
               bit_cnt     <= 6'd1;
               frame_start <= ~ws_h;
               // Compare uses the count of the channel that just ended.
               case (state)
                  UNLOCKED: begin
                     state    <= ALIGN;
                     good_cnt <= 2'd0;
                  end
                  ALIGN: begin
                     if (len_ok) begin
                        good_cnt <= good_cnt + 2'd1;
                        if (good_cnt == 2'(LOCK_CHANS - 1))
                           state <= LOCKED;
                     end else begin
                        good_cnt  <= 2'd0;
                        frame_err <= 1'b1;
                     end
                  end
                  LOCKED: begin
                     if (!len_ok) begin
                        frame_err <= 1'b1;
                        state     <= ALIGN;
                        good_cnt  <= 2'd0;
                     end
                  end
                  default: begin
                     state    <= UNLOCKED;
                     good_cnt <= 2'd0;
                  end
               endcase
            end else if (bit_cnt != 6'd63) begin
               bit_cnt <= bit_cnt + 6'd1;
            end
         end
      end
   end

   assign locked    = (state == LOCKED);
   assign state_dbg = state;

endmodule

// File: tb/tb_clk_rx_sync.sv
// tb_clk_rx_sync: scoreboard bench for clk_rx_sync. The driver emits sclk/ws
// bit by bit and, for every sclk rise, pushes the expected response computed
// by a channel-level reference model; a negedge monitor pops on each
// sclk_rise pulse. Build with +define+CLK_RX_SYNC_TIMEOUT_EN for timeout checks.
module tb_clk_rx_sync;
   import ctrl_pkg::*;

   // clock / reset
   logic        pclk = 1'b0;
   logic        rst_ = 1'b0;
   OP_t         op;
   logic        sclk_in = 1'b0;
   logic        ws_in = 1'b0;
   logic        sclk_rise, sclk_fall, ws_sync, frame_start, locked;
   logic        frame_err, sclk_lost;
   logic [5:0]  bit_cnt;
   sync_state_t state_dbg;

   always #5 pclk = ~pclk;

   int cyc = 0;
   initial forever begin
      @(posedge pclk);
      cyc++;
   end

   clk_rx_sync dut (
      .pclk(pclk), .rst_(rst_), .OP(op), .sclk_in(sclk_in), .ws_in(ws_in),
      .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .ws_sync(ws_sync),
      .frame_start(frame_start), .bit_cnt(bit_cnt), .locked(locked),
      .frame_err(frame_err), .sclk_lost(sclk_lost), .state_dbg(state_dbg)
   );

   // scoreboard state
   int n_checks = 0;
   int n_fail   = 0;
   logic [9:0] exp_q[$];   // {ws, frame_start, frame_err, locked, bit_cnt}
   int lat_q[$];
   int fs_cyc[$];
   int fall_drv = 0, fall_seen = 0, lost_cnt = 0;
   bit model_on = 1'b1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Channel-level reference model
   int m_cnt, m_good, m_len;
   bit m_ws, m_seen, m_locked;

   task automatic model_reset();
      m_cnt = 0; m_good = 0; m_ws = 0; m_seen = 0; m_locked = 0;
   endtask

   task automatic model_timeout();
      m_cnt = 0; m_good = 0; m_seen = 0; m_locked = 0;
   endtask

   task automatic model_rise(input bit w);
      bit fs, fe;
      fs = 0; fe = 0;
      if (w != m_ws) begin
         fs = (w == 1'b0);
         if (m_seen) begin
            if (m_cnt == m_len) begin
               if (!m_locked) begin
                  m_good++;
                  if (m_good >= 2) m_locked = 1;
               end
            end else begin
               fe = 1; m_locked = 0; m_good = 0;
            end
         end
         m_seen = 1; m_cnt = 1; m_ws = w;
      end else begin
         m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
      end
      exp_q.push_back({w, fs, fe, m_locked, 6'(m_cnt)});
   endtask

   // driver tasks
   task automatic sclk_bit(input bit w, input int half);
      @(posedge pclk); #2;
      if (sclk_in && model_on) fall_drv++;
      sclk_in = 1'b0;
      ws_in   = w;
      repeat (half - 1) @(posedge pclk);
      @(posedge pclk); #2;
      sclk_in = 1'b1;
      if (model_on) begin
         model_rise(w);
         lat_q.push_back(cyc);
      end
      repeat (half - 1) @(posedge pclk);
   endtask

   task automatic channel(input bit w, input int len, input int half);
      repeat (len) sclk_bit(w, half);
   endtask

   task automatic idle_low(input int n);
      @(posedge pclk); #2;
      if (sclk_in && model_on) fall_drv++;
      sclk_in = 1'b0;
      repeat (n) @(posedge pclk);
   endtask

   task automatic check_cleared(input string tag);
      @(negedge pclk);
      check({tag, "_sclk_rise"},   sclk_rise, 0);
      check({tag, "_sclk_fall"},   sclk_fall, 0);
      check({tag, "_ws_sync"},     ws_sync, 0);
      check({tag, "_frame_start"}, frame_start, 0);
      check({tag, "_bit_cnt"},     bit_cnt, 0);
      check({tag, "_locked"},      locked, 0);
      check({tag, "_frame_err"},   frame_err, 0);
      check({tag, "_sclk_lost"},   sclk_lost, 0);
      check({tag, "_state"},       state_dbg, UNLOCKED);
   endtask

   // monitor
   initial begin
      logic [9:0] e;
      bit prev_rise;
      int lat;
      prev_rise = 0;
      forever begin
         @(negedge pclk);
         if (sclk_rise) begin
            check("rise_width", prev_rise, 0);
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_rise: got sclk_rise=1 expected none (cycle %0d)", cyc);
            end else begin
               e   = exp_q.pop_front();
               lat = lat_q.pop_front();
               check("ws_sync",     ws_sync,     e[9]);
               check("frame_start", frame_start, e[8]);
               check("frame_err",   frame_err,   e[7]);
               check("locked",      locked,      e[6]);
               check("bit_cnt",     bit_cnt,     e[5:0]);
               check("rise_latency", cyc - lat,  3);
               if (frame_start) fs_cyc.push_back(cyc);
            end
         end else if (frame_start || frame_err) begin
            n_checks++; n_fail++;
            $display("FAIL stray_pulse: got frame_start=%0d frame_err=%0d expected 0 (cycle %0d)",
                     frame_start, frame_err, cyc);
         end
         if (sclk_fall) fall_seen++;
         if (sclk_lost) lost_cnt++;
         prev_rise = sclk_rise;
      end
   end

   initial begin
      int len, half;
      bit w;
      op.mode = ST; op.stereo = 1'b1; op.frame_size = f16bits;
      m_len = 16;
      model_reset();

      // reset state
      repeat (3) @(posedge pclk);
      check_cleared("reset");
      #2 rst_ = 1'b1;
      repeat (4) @(posedge pclk);

      // f16 stereo, sclk period 8: lock after 3rd boundary, frame_start every 256
      fs_cyc.delete();
      for (int c = 0; c < 6; c++) channel((c % 2) == 0, 16, 4);
      repeat (6) @(posedge pclk);
      check("fs_count", fs_cyc.size(), 3);
      for (int i = 1; i < fs_cyc.size(); i++)
         check("fs_period", fs_cyc[i] - fs_cyc[i-1], 256);
      check("locked_steady", locked, 1);

      // short channel while locked, then relock
      channel(1'b1, 15, 4);
      channel(1'b0, 16, 4);
      channel(1'b1, 16, 4);
      channel(1'b0, 16, 4);
      channel(1'b1, 16, 4);
      check("relocked", locked, 1);

      // async reset mid-channel (ws low, sclk low)
      channel(1'b0, 8, 4);
      idle_low(6);
      #2 rst_ = 1'b0;
      model_reset();
      check_cleared("midreset");
      #2 rst_ = 1'b1;
      channel(1'b0, 8, 4);
      channel(1'b1, 16, 4);
      channel(1'b0, 16, 4);
      channel(1'b1, 16, 4);

      // switch to MT: cleared and held, sclk activity ignored
      idle_low(6);
      op.mode = MT;
      repeat (2) @(posedge pclk);
      check_cleared("mode_mt");
      model_on = 1'b0;
      channel(1'b0, 4, 4);
      idle_low(4);
      check_cleared("mode_mt_toggle");
      model_on = 1'b1;
      model_reset();
      op.mode = SR;
      channel(1'b0, 5, 4);
      channel(1'b1, 16, 4);
      channel(1'b0, 16, 4);
      channel(1'b1, 16, 4);
      check("locked_after_mode", locked, 1);

      // sclk held high for 80 pclk while locked
      lost_cnt = 0;
      repeat (80) @(posedge pclk);
      @(negedge pclk);
`ifdef CLK_RX_SYNC_TIMEOUT_EN
      model_timeout();
      check("timeout_pulses", lost_cnt, 1);
      check("timeout_locked", locked, 0);
      check("timeout_bit_cnt", bit_cnt, 0);
`else
      check("timeout_pulses", lost_cnt, 0);
      check("timeout_locked", locked, m_locked);
      check("timeout_bit_cnt", bit_cnt, m_cnt);
`endif
      channel(1'b1, 3, 4);
      channel(1'b0, 16, 4);
      channel(1'b1, 16, 4);
      channel(1'b0, 16, 4);

      // f32 with 40-rise channels: error at each boundary, never locked
      op.frame_size = f32bits;
      m_len = 32;
      for (int c = 0; c < 4; c++) channel((c % 2) == 0, 40, 4);
      check("f32_never_locked", locked, 0);

      // saturation then randomized traffic
      channel(1'b0, 70, 3);
      w = 1'b1;
      for (int c = 0; c < 16; c++) begin
         op.mode       = ($urandom_range(0, 1) == 0) ? ST : SR;
         op.stereo     = 1'($urandom_range(0, 1));
         op.frame_size = ($urandom_range(0, 3) == 0) ? f32bits : f16bits;
         m_len = (op.frame_size == f32bits) ? 32 : 16;
         case ($urandom_range(0, 9))
            7:       len = m_len - 1;
            8:       len = m_len + 1;
            default: len = m_len;
         endcase
         half = $urandom_range(3, 6);
         channel(w, len, half);
         w = ~w;
      end

      idle_low(10);
      check("queue_drained", exp_q.size(), 0);
      check("fall_pulses", fall_seen, fall_drv);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
